rcb_wr_sched: RTL

RCB_WR_SCHED -- requirements
Module: rcb_wr_sched

---
 rtl/rcb_wr_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rcb_wr_sched.sv
// Write scheduler for the four RCBs: buffers host writes in order and issues
// them only when the target RCB is not being read by the SEF.
//
// state | meaning
// IDLE  | buffer empty, nothing to issue
// ISSUE | head entry present and issuing (or about to)
// STALL | head entry blocked by an SEF read on its target RCB
module rcb_wr_sched #(
    parameter int DEPTH      = 4,
    parameter int AW         = 10,
    parameter int DW         = 64,
    parameter int STARVE_MAX = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       hpb_wr_valid,
    output logic                       hpb_wr_ready,
    input  logic [1:0]                 hpb_wr_sel,
    input  logic [AW-1:0]              hpb_wr_addr,
    input  logic [DW-1:0]              hpb_wr_data,
    input  logic                       sef_rd_srcb,
    input  logic                       sef_rd_prcb,
    input  logic                       sef_rd_vrcb,
    input  logic                       sef_rd_orcb,
    output logic [3:0]                 rcb_we,
    output logic [AW-1:0]              rcb_waddr,
    output logic [DW-1:0]              rcb_wdata,
    output logic                       wr_pending,
    output logic [$clog2(DEPTH):0]     fifo_level,
    input  logic                       starve_clr,
    output logic                       starve_err,
    output logic [15:0]                wr_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t state_q, state_nxt;

    logic [1:0]    sel_mem  [DEPTH];
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_nxt;
    logic [SW-1:0] starve_cnt_q;
    logic          starve_err_q;
    logic [15:0]   wr_cnt_q;

    logic [3:0]    sef_rd;
    logic [1:0]    head_sel;
    logic          head_blocked;
    logic          push;
    logic          pop;

    assign sef_rd       = {sef_rd_orcb, sef_rd_vrcb, sef_rd_prcb, sef_rd_srcb};
    assign head_sel     = sel_mem[rd_ptr_q];
    assign head_blocked = sef_rd[head_sel];

    // Ready comes from the registered level only, so a full buffer stays
    // unready even in a cycle where the head pops.
    assign hpb_wr_ready = (level_q < LW'(DEPTH));
    assign push         = hpb_wr_valid & hpb_wr_ready;
    assign wr_pending   = (level_q != '0);
    assign pop          = wr_pending & ~head_blocked;

    always_comb begin
        rcb_we = 4'b0000;
        if (pop) begin
            rcb_we[head_sel] = 1'b1;
        end
    end

    assign rcb_waddr  = addr_mem[rd_ptr_q];
    assign rcb_wdata  = data_mem[rd_ptr_q];
    assign fifo_level = level_q;
    assign starve_err = starve_err_q;
    assign wr_cnt     = wr_cnt_q;

    always_comb begin
        level_nxt = level_q;
        if (push && !pop) begin
            level_nxt = level_q + 1'b1;
        end else if (!push && pop) begin
            level_nxt = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sel_mem[wr_ptr_q]  <= hpb_wr_sel;
            addr_mem[wr_ptr_q] <= hpb_wr_addr;
            data_mem[wr_ptr_q] <= hpb_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            level_q <= level_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (pop && (level_nxt == '0)) begin
                    state_nxt = IDLE;
                end else if (head_blocked) begin
                    state_nxt = STALL;
                end
            end
            STALL: begin
                if (pop) begin
                    state_nxt = (level_nxt == '0) ? IDLE : ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Starvation is status only; it never forces a write past an SEF read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
            starve_err_q <= 1'b0;
        end else begin
            if (pop) begin
                starve_cnt_q <= '0;
            end else if ((state_q == STALL) && head_blocked && (starve_cnt_q != STARVE_TOP)) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end

            if ((state_q == STALL) && head_blocked && (starve_cnt_q == STARVE_TOP)) begin
                starve_err_q <= 1'b1;
            end else if (starve_clr) begin
                starve_err_q <= 1'b0;
            end
        end
    end

endmodule
